// File: rtl/iterative_divider_pkg.sv
// Shared constants for the execute-stage divider.
// Holds the 2-bit div_op encodings, the divider FSM state encoding, the ALU
// division opcodes and the decoder helper mapping those opcodes to div_op.
package iterative_divider_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'b00,
    DIV_STATE_CALC = 2'b01,
    DIV_STATE_DONE = 2'b10
  } div_state_e;

  // ALU opcodes routed to the divider instead of the combinational ALU.
  localparam logic [3:0] ALU_DIV  = 4'hC;
  localparam logic [3:0] ALU_DIVU = 4'hD;
  localparam logic [3:0] ALU_REM  = 4'hE;
  localparam logic [3:0] ALU_REMU = 4'hF;

  function automatic div_op_e div_op_from_alu(input logic [3:0] alu_op);
    div_op_e op;
    case (alu_op)
      ALU_DIV:  op = DIV_OP_DIV;
      ALU_DIVU: op = DIV_OP_DIVU;
      ALU_REM:  op = DIV_OP_REM;
      ALU_REMU: op = DIV_OP_REMU;
      default:  op = DIV_OP_DIVU;
    endcase
    return op;
  endfunction

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/iterative_divider_if.sv
// Request/response bundle between execute-stage control and the divider.
//   start, div_op, operand_a, operand_b, flush : requester -> divider
//   busy, done, result                          : divider -> requester
// master = requester (pipeline control), slave = divider.
interface iterative_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       div_op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, div_op, operand_a, operand_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, div_op, operand_a, operand_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/iterative_divider_step.sv
// One radix-2 restoring division step, purely combinational.
//   partial_rem, quotient, divisor : current iteration state
//   next_rem, next_quotient        : state after shifting in one dividend bit
// The quotient register doubles as the dividend shifter: its MSB feeds the
// remainder and the new quotient bit enters at the LSB.
module iterative_divider_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quotient
);

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    rem_shift = {partial_rem, quotient[WIDTH-1]};
    ge        = (rem_shift >= {1'b0, divisor});
    // When ge holds the true difference is below divisor, so the low WIDTH
    // bits of the WIDTH+1-bit subtraction are exact.
    diff      = rem_shift[WIDTH-1:0] - divisor;
    if (ge) begin
      next_rem      = diff;
      next_quotient = {quotient[WIDTH-2:0], 1'b1};
    end else begin
      next_rem      = rem_shift[WIDTH-1:0];
      next_quotient = {quotient[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous reset, active low
//   bus   : slave side of iterative_divider_if (start/div_op/operands/flush
//           in; busy/done/result out). All outputs are registered.
// Divide-by-zero and signed overflow are resolved at start and complete one
// cycle later; all other operations take WIDTH step cycles plus one.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  iterative_divider_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  div_op_e          op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem, step_quotient;

  iterative_divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .partial_rem  (rem_q),
    .quotient     (quotient_q),
    .divisor      (divisor_q),
    .next_rem     (step_rem),
    .next_quotient(step_quotient)
  );

  div_op_e          in_op;
  logic             in_signed, in_sign_a, in_sign_b;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;

  always_comb begin
    in_op     = div_op_e'(bus.div_op);
    in_signed = op_is_signed(in_op);
    in_sign_a = in_signed & bus.operand_a[WIDTH-1];
    in_sign_b = in_signed & bus.operand_b[WIDTH-1];
    in_mag_a  = in_sign_a ? ('0 - bus.operand_a) : bus.operand_a;
    in_mag_b  = in_sign_b ? ('0 - bus.operand_b) : bus.operand_b;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    divisor_d  = divisor_q;
    quotient_d = quotient_q;
    rem_d      = rem_q;
    count_d    = count_q;
    result_d   = result_q;

    case (state_q)
      DIV_STATE_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d       = in_op;
          sign_a_d   = in_sign_a;
          sign_b_d   = in_sign_b;
          divisor_d  = in_mag_b;
          quotient_d = in_mag_a;
          rem_d      = '0;
          count_d    = CW'(WIDTH - 1);
          if (bus.operand_b == '0) begin
            result_d = op_is_rem(in_op) ? bus.operand_a : '1;
            state_d  = DIV_STATE_DONE;
          end else if (in_signed && bus.operand_a == MOST_NEG && bus.operand_b == '1) begin
            result_d = op_is_rem(in_op) ? '0 : MOST_NEG;
            state_d  = DIV_STATE_DONE;
          end else begin
            state_d  = DIV_STATE_CALC;
          end
        end
      end

      DIV_STATE_CALC: begin
        if (bus.flush) begin
          state_d = DIV_STATE_IDLE;
        end else begin
          quotient_d = step_quotient;
          rem_d      = step_rem;
          count_d    = count_q - 1'b1;
          if (count_q == '0) begin
            if (op_is_rem(op_q)) begin
              result_d = sign_a_q ? ('0 - step_rem) : step_rem;
            end else begin
              result_d = (sign_a_q ^ sign_b_q) ? ('0 - step_quotient) : step_quotient;
            end
            state_d = DIV_STATE_DONE;
          end
        end
      end

      DIV_STATE_DONE: state_d = DIV_STATE_IDLE;

      default: state_d = DIV_STATE_IDLE;
    endcase

    // Status flags follow the next state so they are plain flop outputs.
    busy_d = (state_d != DIV_STATE_IDLE);
    done_d = (state_d == DIV_STATE_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= DIV_STATE_IDLE;
      op_q       <= DIV_OP_DIV;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      divisor_q  <= '0;
      quotient_q <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      divisor_q  <= divisor_d;
      quotient_q <= quotient_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider (WIDTH=32): directed cases,
// randomized operations against an arithmetic reference, and control cases
// (ignored start, flush, start+flush, asynchronous reset).
module tb_iterative_divider;
  import iterative_divider_pkg::*;

  localparam int unsigned W = 32;
  localparam int MAX_WAIT = 40;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  iterative_divider_if #(.WIDTH(W)) bus ();

  iterative_divider #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic is_rem;
    logic is_signed;
    is_rem    = op[1];
    is_signed = !op[0];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return is_rem ? 32'd0 : 32'h8000_0000;
    if (is_signed) return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return is_rem ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  // Called at a falling edge; leaves at a falling edge with the divider idle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int lat;
    int busy_low;
    exp = ref_result(op, a, b);
    bus.start = 1'b1; bus.div_op = op; bus.operand_a = a; bus.operand_b = b;
    @(negedge clock);
    bus.start = 1'b0; bus.div_op = 2'($urandom); bus.operand_a = $urandom; bus.operand_b = $urandom;
    lat = 1;
    busy_low = 0;
    while (bus.done !== 1'b1 && lat < MAX_WAIT) begin
      if (bus.busy !== 1'b1) busy_low++;
      @(negedge clock);
      lat++;
    end
    if (bus.busy !== 1'b1) busy_low++;
    check_eq({tag, "_latency"}, 32'(lat), 32'(ref_latency(op, a, b)));
    check_eq({tag, "_result"}, bus.result, exp);
    check_eq({tag, "_busy_low_cycles"}, 32'(busy_low), 32'd0);
    @(negedge clock);
    check_eq({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_idle_done"}, {31'd0, bus.done}, 32'd0);
    check_eq({tag, "_held"}, bus.result, exp);
  endtask

  initial begin
    logic [31:0] ra, rb, prev;
    logic [1:0]  rop;
    int done_seen;
    n_checks = 0;
    n_errors = 0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.div_op = 2'b00;
    bus.operand_a = '0; bus.operand_b = '0;
    reset = 1'b0;
    #1;
    check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("reset_done", {31'd0, bus.done}, 32'd0);
    check_eq("reset_result", bus.result, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_op("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7);
    run_op("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7);
    run_op("div_m7_2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2);
    run_op("div_7_m2", DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE);
    run_op("div_by0", DIV_OP_DIV, 32'h1234_5678, 32'd0);
    run_op("divu_by0", DIV_OP_DIVU, 32'h1234_5678, 32'd0);
    run_op("rem_by0", DIV_OP_REM, 32'h1234_5678, 32'd0);
    run_op("remu_by0", DIV_OP_REMU, 32'h1234_5678, 32'd0);
    run_op("div_ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_ovf_ops", DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_max_1", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    run_op("remu_max_16", DIV_OP_REMU, 32'hFFFF_FFFF, 32'h10);
    run_op("divu_5_9", DIV_OP_DIVU, 32'd5, 32'd9);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = $urandom_range(0, 1000);
        2: ra = 32'h8000_0000;
        default: ra = 32'd0 - $urandom_range(0, 1000);
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 20);
        3: rb = 32'd0 - $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op("random", rop, ra, rb);
    end

    // A second start while busy must be dropped; the first result is delivered.
    bus.start = 1'b1; bus.div_op = DIV_OP_DIVU; bus.operand_a = 32'd1000; bus.operand_b = 32'd10;
    @(negedge clock);
    bus.start = 1'b0;
    done_seen = 0;
    for (int c = 1; c <= MAX_WAIT; c++) begin
      if (c == 5) begin
        bus.start = 1'b1; bus.div_op = DIV_OP_REMU; bus.operand_a = 32'd77; bus.operand_b = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1 && done_seen == 0) begin
        done_seen = c;
        check_eq("ignored_start_result", bus.result, 32'd100);
      end
      @(negedge clock);
    end
    bus.start = 1'b0;
    check_eq("ignored_start_latency", 32'(done_seen), 32'd33);
    check_eq("ignored_start_idle", {31'd0, bus.busy}, 32'd0);

    // Flush at cycle 10: idle one cycle later, no done, result untouched.
    prev = bus.result;
    bus.start = 1'b1; bus.div_op = DIV_OP_DIV; bus.operand_a = 32'd5000; bus.operand_b = 32'd3;
    @(negedge clock);
    bus.start = 1'b0;
    done_seen = 0;
    for (int c = 1; c <= MAX_WAIT; c++) begin
      bus.flush = (c == 10);
      if (c == 11) check_eq("flush_busy", {31'd0, bus.busy}, 32'd0);
      if (bus.done === 1'b1) done_seen++;
      @(negedge clock);
    end
    bus.flush = 1'b0;
    check_eq("flush_no_done", 32'(done_seen), 32'd0);
    check_eq("flush_result_kept", bus.result, prev);

    // Start and flush together in idle: nothing accepted.
    bus.start = 1'b1; bus.flush = 1'b1; bus.div_op = DIV_OP_DIVU;
    bus.operand_a = 32'd9; bus.operand_b = 32'd0;
    @(negedge clock);
    bus.start = 1'b0; bus.flush = 1'b0;
    check_eq("start_flush_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("start_flush_done", {31'd0, bus.done}, 32'd0);

    // Asynchronous reset at cycle 20 of an operation.
    run_op("pre_reset", DIV_OP_DIVU, 32'd200, 32'd3);
    bus.start = 1'b1; bus.div_op = DIV_OP_DIVU; bus.operand_a = 32'd400; bus.operand_b = 32'd7;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (19) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_reset_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("async_reset_done", {31'd0, bus.done}, 32'd0);
    check_eq("async_reset_result", bus.result, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.done === 1'b1) done_seen++;
    end
    check_eq("reset_abandons_op", 32'(done_seen), 32'd0);
    run_op("post_reset_divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
